// File: rtl/seq_generator.sv
// Serial pattern generator: sends a PAT_W-bit pattern MSB-first, repeat_n times, with gap idle cycles between repetitions.
// Optional SEQ_GEN_LFSR_FILL_EN fills gap cycles with an 8-bit LFSR bit instead of 0.
module seq_generator #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [CNT_W-1:0] gap,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           state, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic             x_d, valid_d, busy_d, done_d;
  logic             fill;

`ifdef SEQ_GEN_LFSR_FILL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // x^8+x^6+x^5+x^4+1, stepping only on cycles spent in GAP.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state == GAP)
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign fill = lfsr_d[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 8'hA5;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign fill = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it unassigned, which would infer a latch.
    state_d = state;
    pat_d   = pat_q;
    idx_d   = idx_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (repeat_n != '0) begin
            pat_d   = pattern;
            rep_d   = repeat_n;
            gap_d   = gap;
            idx_d   = IDX_TOP;
            state_d = SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEND: begin
        if (idx_q == '0) begin
          rep_d = rep_q - CNT_W'(1);
          if (rep_q == CNT_W'(1)) begin
            state_d = DONE;
          end else if (gap_q != '0) begin
            state_d = GAP;
            gcnt_d  = gap_q;
          end else begin
            idx_d = IDX_TOP;
          end
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      GAP: begin
        if (gcnt_q == CNT_W'(1)) begin
          state_d = SEND;
          idx_d   = IDX_TOP;
          gcnt_d  = '0;
        end else begin
          gcnt_d = gcnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered with zero added latency.
  always_comb begin
    x_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_d)
      SEND: begin
        x_d     = pat_d[idx_d];
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      GAP: begin
        x_d    = fill;
        busy_d = 1'b1;
      end
      DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    if (reset) begin
      state  <= IDLE;
      pat_q  <= '0;
      idx_q  <= '0;
      rep_q  <= '0;
      gap_q  <= '0;
      gcnt_q <= '0;
      x      <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      pat_q  <= pat_d;
      idx_q  <= idx_d;
      rep_q  <= rep_d;
      gap_q  <= gap_d;
      gcnt_q <= gcnt_d;
      x      <= x_d;
      valid  <= valid_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_generator.sv
// Directed self-checking bench for seq_generator (PAT_W=4, CNT_W=4); gap-fill expectations follow SEQ_GEN_LFSR_FILL_EN.
module tb_seq_generator;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] repeat_n;
  logic [3:0] gap;
  logic       x, valid, busy, done;

  int total = 0;
  int bad   = 0;
  logic [7:0] m_lfsr;

  seq_generator #(.PAT_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .repeat_n(repeat_n), .gap(gap), .x(x), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check all four outputs for the current cycle, then move to the next cycle.
  task automatic check_cycle(input string tag, input logic xe, input logic ve,
                             input logic be, input logic de);
    check({tag, ".x"},     x,     xe);
    check({tag, ".valid"}, valid, ve);
    check({tag, ".busy"},  busy,  be);
    check({tag, ".done"},  done,  de);
    @(negedge clk);
  endtask

  task automatic launch(input logic [3:0] pat, input logic [3:0] rep, input logic [3:0] gp);
    pattern  = pat;
    repeat_n = rep;
    gap      = gp;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  function automatic logic gap_bit();
`ifdef SEQ_GEN_LFSR_FILL_EN
    return m_lfsr[0];
`else
    return 1'b0;
`endif
  endfunction

  task automatic step_lfsr();
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  // Expected burst: rep copies of pat MSB-first, gp fill cycles between copies, one done cycle, then idle.
  task automatic run_burst(input string tag, input logic [3:0] pat,
                           input logic [3:0] rep, input logic [3:0] gp);
    launch(pat, rep, gp);
    for (int r = 0; r < int'(rep); r++) begin
      for (int b = 3; b >= 0; b--) check_cycle({tag, ".bit"}, pat[b], 1'b1, 1'b1, 1'b0);
      if (r < int'(rep) - 1)
        for (int g = 0; g < int'(gp); g++) begin
          check_cycle({tag, ".gap"}, gap_bit(), 1'b0, 1'b1, 1'b0);
          step_lfsr();
        end
    end
    check_cycle({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b1);
    check_cycle({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    m_lfsr = 8'hA5;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    pattern  = '0;
    repeat_n = '0;
    gap      = '0;
    m_lfsr   = 8'hA5;
    @(negedge clk);
    check_cycle("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    check_cycle("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // Single burst 1101, hand-written expectations.
    launch(4'b1101, 4'd1, 4'd0);
    check_cycle("single.b3", 1'b1, 1'b1, 1'b1, 1'b0);
    check_cycle("single.b2", 1'b1, 1'b1, 1'b1, 1'b0);
    check_cycle("single.b1", 1'b0, 1'b1, 1'b1, 1'b0);
    check_cycle("single.b0", 1'b1, 1'b1, 1'b1, 1'b0);
    check_cycle("single.done", 1'b0, 1'b0, 1'b1, 1'b1);
    check_cycle("single.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    run_burst("gapped", 4'b1011, 4'd3, 4'd2);
    run_burst("b2b", 4'b0110, 4'd2, 4'd0);

    // repeat_n=0: done right after start, no valid bits.
    launch(4'b1111, 4'd0, 4'd3);
    check_cycle("zero.done", 1'b0, 1'b0, 1'b1, 1'b1);
    check_cycle("zero.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // Busy protection: a second request held through SEND/DONE is ignored.
    launch(4'b1101, 4'd1, 4'd0);
    check_cycle("busy.b3", 1'b1, 1'b1, 1'b1, 1'b0);
    pattern  = 4'b0010;
    repeat_n = 4'd5;
    gap      = 4'd1;
    start    = 1'b1;
    check_cycle("busy.b2", 1'b1, 1'b1, 1'b1, 1'b0);
    check_cycle("busy.b1", 1'b0, 1'b1, 1'b1, 1'b0);
    check_cycle("busy.b0", 1'b1, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    check_cycle("busy.done", 1'b0, 1'b0, 1'b1, 1'b1);
    check_cycle("busy.idle0", 1'b0, 1'b0, 1'b0, 1'b0);
    check_cycle("busy.idle1", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during the 2nd bit: outputs drop asynchronously and no done follows.
    launch(4'b1101, 4'd2, 4'd1);
    check_cycle("rst.b3", 1'b1, 1'b1, 1'b1, 1'b0);
    check("rst.b2.x", x, 1'b1);
    #1 reset = 1'b1;
    m_lfsr = 8'hA5;
    #1;
    check("rst.async.x", x, 1'b0);
    check("rst.async.valid", valid, 1'b0);
    check("rst.async.busy", busy, 1'b0);
    check("rst.async.done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    check_cycle("rst.idle0", 1'b0, 1'b0, 1'b0, 1'b0);
    check_cycle("rst.idle1", 1'b0, 1'b0, 1'b0, 1'b0);
    run_burst("rst.after", 4'b0110, 4'd1, 4'd0);

    // Counter maxima, then the gap-fill scenario from a fresh seed.
    run_burst("max", 4'b1001, 4'd15, 4'd15);
    apply_reset();
    run_burst("fill", 4'b1011, 4'd2, 4'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_generator.md
# seq_generator

Serial pattern generator that drives the single-bit `x` input of the sequence detector. It emits a programmable PAT_W-bit pattern MSB-first, one bit per clock, for a programmed number of repetitions with an optional idle gap between repetitions. It uses a start/busy/done handshake so a bench or higher-level controller can produce known detector stimulus on chip.

## Interface
Parameters:
- `PAT_W`, 4: pattern length in bits (≥2).
- `CNT_W`, 4: width of repeat and gap counters.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: request a burst; sampled only in IDLE.
- `pattern` in PAT_W: pattern to send, latched on accepted start.
- `repeat_n` in CNT_W: number of pattern repetitions, latched on accepted start.
- `gap` in CNT_W: idle cycles between repetitions, latched on accepted start.
- `x` out 1: serial data to the detector, registered.
- `valid` out 1: high while `x` carries a pattern bit, registered.
- `busy` out 1: high from the accepted start through the DONE cycle, registered.
- `done` out 1: one-cycle pulse at burst end, registered.

## Operation
- States: IDLE, SEND, GAP, DONE.
- Reset (async, at any time, including mid-burst):
  - state goes to IDLE.
  - `x`, `valid`, `busy` and `done` all go to 0.
  - bit index, repeat counter and gap counter clear.
- IDLE with `start`=1 and `repeat_n`≠0:
  - latch `pattern`, `repeat_n`, `gap`.
  - go to SEND with bit index PAT_W-1.
- IDLE with `start`=1 and `repeat_n`=0: go straight to DONE. No bits are sent.
- SEND:
  - `x` = latched_pattern[bit_index], `valid`=1.
  - Bit index decrements each cycle.
  - After bit 0, the repeat counter decrements.
- After the last bit of a repetition:
  - Repetitions remain and gap≠0: go to GAP for exactly `gap` cycles, then SEND at bit PAT_W-1.
  - Repetitions remain and gap=0: next repetition follows back-to-back with no bubble.
  - No repetitions remain: go to DONE.
- GAP: `valid`=0. `x` = gap fill value (see Configuration).
- DONE: lasts one cycle with `done`=1, `busy`=1, `valid`=0, `x`=0. Then IDLE.
- `start` is ignored in SEND, GAP and DONE. Inputs are not re-latched mid-burst.
- IDLE: `x`=0, `valid`=0, `busy`=0, `done`=0.

## Timing
- Start sampled at edge N → first bit on `x`, with `valid`=1 and `busy`=1, after edge N (latency 1).
- `x` changes only on rising edges. The detector samples a stable value on the next edge.
- Burst length in cycles with `valid` or gap: repeat_n·PAT_W + (repeat_n−1)·gap.
- `done` is high in the cycle after the last bit. The next start is accepted at the edge after `done` falls (IDLE).
- Counters do not wrap. The maximum `repeat_n`/`gap` is 2^CNT_W−1, handled exactly.
- Reset asserted mid-burst: outputs are 0 immediately (async). No `done` pulse is produced. The burst is abandoned.

## Configuration
- `SEQ_GEN_LFSR_FILL_EN` defined: an 8-bit Fibonacci LFSR is present.
  - Polynomial x^8+x^6+x^5+x^4+1.
  - Seed 8'hA5 on reset.
  - The LFSR advances only in GAP cycles.
  - In GAP, `x` = lfsr[0].
  - Purpose: test detector robustness against noise between patterns.
- Not defined: no LFSR logic. `x`=0 in GAP.
- `valid` behaviour is identical in both builds.

## Test plan
- Single burst: pattern=4'b1101, repeat_n=1, gap=0, start at edge N.
  - `x` = 1,1,0,1 on cycles N+1..N+4 with `valid`=1.
  - `done`=1 on N+5.
  - `busy` falls after N+5.
- Gapped repeats: pattern=4'b1011, repeat_n=3, gap=2.
  - Stream is 1011 00 1011 00 1011 (16 cycles).
  - `valid` low only in the four gap cycles.
  - Single `done` pulse afterwards.
- Back-to-back, zero repeat:
  - repeat_n=2, gap=0, pattern=4'b0110 → 01100110 with `valid` continuously high.
  - Then repeat_n=0 → `done` the cycle after start, `valid` never high.
- Busy protection: assert start with a different pattern during SEND → current burst completes unchanged. The new request is not taken unless start is still high in IDLE.
- Reset mid-burst: assert reset during the 2nd bit → all outputs 0 immediately, no `done`. After release, a new start is accepted normally.
- With `SEQ_GEN_LFSR_FILL_EN`: repeat_n=2, gap=8 → gap bits match a reference LFSR model seeded 8'hA5, and `valid`=0 throughout the gap.
